// File: rtl/keypad_scan_ctrl.sv
// Scan controller for a 4x3 matrix keypad: column strobing, press/release debounce,
// key encoding and a valid/ready output. Define KEYPAD_REPEAT_EN to add auto-repeat.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV      = 4,
    parameter int DEBOUNCE      = 8,
    parameter int REPEAT_PERIOD = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_en,
    input  logic [3:0] row_in,
    output logic [2:0] col_drive,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overrun,
    input  logic       overrun_clr,
    output logic       busy
);
    localparam int SC_W = $clog2(SCAN_DIV);
    localparam int DC_W = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE - 1);

    if (SCAN_DIV < 3 || DEBOUNCE < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
        $error("keypad_scan_ctrl: SCAN_DIV must be >= 3, DEBOUNCE and REPEAT_PERIOD >= 2");
    end

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      sync1_q, rs_q;
    logic [1:0]      cur_col_q, cur_col_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic [DC_W-1:0] dc_q, dc_d;
    logic [DC_W-1:0] rc_q, rc_d;
    logic [3:0]      cap_row_q, cap_row_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            key_valid_q, key_valid_d;
    logic            overrun_q, overrun_d;
    logic            emit;
    logic            drop;
`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_PERIOD - 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

    function automatic logic [1:0] next_col(input logic [1:0] col);
        return (col == 2'd2) ? 2'd0 : col + 2'd1;
    endfunction

    function automatic logic [2:0] col_onehot(input logic [1:0] col);
        case (col)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Rows 0-2 are the digit keys 1..9; row 3 holds *, 0, #.
    function automatic logic [3:0] encode_key(input logic [3:0] row_oh, input logic [1:0] col);
        logic [3:0] c4;
        c4 = {2'b00, col};
        case (row_oh)
            4'b0001: return c4 + 4'd1;
            4'b0010: return c4 + 4'd4;
            4'b0100: return c4 + 4'd7;
            default: begin
                case (col)
                    2'd0:    return 4'hA;
                    2'd1:    return 4'h0;
                    default: return 4'hB;
                endcase
            end
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            sync1_q     <= '0;
            rs_q        <= '0;
            cur_col_q   <= '0;
            sc_q        <= '0;
            dc_q        <= '0;
            rc_q        <= '0;
            cap_row_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= row_in;
            rs_q        <= sync1_q;
            cur_col_q   <= cur_col_d;
            sc_q        <= sc_d;
            dc_q        <= dc_d;
            rc_q        <= rc_d;
            cap_row_q   <= cap_row_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
`ifdef KEYPAD_REPEAT_EN
            rpt_q       <= rpt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_col_d = cur_col_q;
        sc_d      = sc_q;
        dc_d      = dc_q;
        rc_d      = rc_q;
        cap_row_d = cap_row_q;
        emit      = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d     = rpt_q;
`endif
        if (!scan_en) begin
            state_d   = SCAN;
            cur_col_d = '0;
            sc_d      = '0;
            dc_d      = '0;
            rc_d      = '0;
`ifdef KEYPAD_REPEAT_EN
            rpt_d     = '0;
`endif
        end else begin
            case (state_q)
                SCAN: begin
                    if (sc_q == SC_LAST) begin
                        sc_d = '0;
                        // Multiple rows in one column is treated as ghosting, same as no key.
                        if ($onehot(rs_q)) begin
                            cap_row_d = rs_q;
                            dc_d      = '0;
                            state_d   = DEB_PRESS;
                        end else begin
                            cur_col_d = next_col(cur_col_q);
                        end
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (rs_q == cap_row_q) begin
                        if (dc_q == DC_LAST) begin
                            emit    = 1'b1;
                            rc_d    = '0;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rpt_d   = '0;
`endif
                        end else begin
                            dc_d = dc_q + 1'b1;
                        end
                    end else begin
                        state_d   = SCAN;
                        cur_col_d = next_col(cur_col_q);
                        sc_d      = '0;
                    end
                end
                HELD: begin
                    if (rs_q == 4'b0000) begin
`ifdef KEYPAD_REPEAT_EN
                        rpt_d = '0;
`endif
                        if (rc_q == DC_LAST) begin
                            rc_d      = '0;
                            state_d   = SCAN;
                            cur_col_d = next_col(cur_col_q);
                            sc_d      = '0;
                        end else begin
                            rc_d = rc_q + 1'b1;
                        end
                    end else begin
                        rc_d = '0;
`ifdef KEYPAD_REPEAT_EN
                        if (rs_q == cap_row_q) begin
                            if (rpt_q == RPT_LAST) begin
                                emit  = 1'b1;
                                rpt_d = '0;
                            end else begin
                                rpt_d = rpt_q + 1'b1;
                            end
                        end
`endif
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    // An emit with an unconsumed key pending (and no same-cycle accept) is dropped.
    assign drop = emit && key_valid_q && !key_ready;

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        if (emit) begin
            if (!drop) begin
                key_code_d  = encode_key(cap_row_q, cur_col_q);
                key_valid_d = 1'b1;
            end
        end else if (key_ready) begin
            key_valid_d = 1'b0;
        end
        overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
    end

    assign col_drive = scan_en ? col_onehot(cur_col_q) : 3'b000;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != SCAN);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a pin-level keypad model (SCAN_DIV=4, DEBOUNCE=8).
module tb_keypad_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_en;
    logic [3:0] row_in;
    logic [2:0] col_drive;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overrun;
    logic       overrun_clr;
    logic       busy;

    logic       raw_en;
    logic [3:0] raw_val;
    logic       ghost;
    logic       key_down;
    logic [1:0] key_r, key_c;

    int errors = 0;
    int checks = 0;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE(8), .REPEAT_PERIOD(64)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .row_in(row_in),
        .col_drive(col_drive), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .overrun(overrun), .overrun_clr(overrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key connects its row to its column strobe.
    always_comb begin
        row_in = 4'b0000;
        if (raw_en)
            row_in = raw_val;
        else if (ghost && col_drive[0])
            row_in = 4'b0011;
        else if (key_down && col_drive[key_c])
            row_in = 4'b0001 << key_r;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; scan_en = 1'b1; key_ready = 1'b0; overrun_clr = 1'b0;
        raw_en = 1'b1; raw_val = 4'b1111; ghost = 1'b0;
        key_down = 1'b0; key_r = 2'd0; key_c = 2'd0;

        cyc(3);
        chk("rst_col",   8'(col_drive), 8'h01);
        chk("rst_code",  8'(key_code),  8'h00);
        chk("rst_valid", 8'(key_valid), 8'h00);
        chk("rst_ovr",   8'(overrun),   8'h00);
        chk("rst_busy",  8'(busy),      8'h00);

        rst_n = 1'b1; raw_en = 1'b0;
        press(2'd1, 2'd1);
        cyc(7);
        chk("k5_col_scan", 8'(col_drive), 8'h02);
        chk("k5_busy_pre", 8'(busy),      8'h00);
        cyc(1);
        chk("k5_busy_deb", 8'(busy), 8'h01);
        cyc(7);
        chk("k5_valid_early", 8'(key_valid), 8'h00);
        cyc(1);
        chk("k5_valid", 8'(key_valid), 8'h01);
        chk("k5_code",  8'(key_code),  8'h05);
        cyc(10);
        chk("k5_valid_hold", 8'(key_valid), 8'h01);
        chk("k5_col_held",   8'(col_drive), 8'h02);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        chk("k5_ack", 8'(key_valid), 8'h00);
        cyc(10);
        key_down = 1'b0;
        cyc(9);
        chk("k5_rel_col_hold", 8'(col_drive), 8'h02);
        chk("k5_rel_busy",     8'(busy),      8'h01);
        cyc(1);
        chk("k5_rel_col_next", 8'(col_drive), 8'h04);
        chk("k5_rel_scan",     8'(busy),      8'h00);
        chk("k5_no_repeat",    8'(key_valid), 8'h00);

        press(2'd2, 2'd2);
        cyc(2);
        key_down = 1'b0;
        cyc(2);
        key_down = 1'b1;
        chk("b9_deb_enter", 8'(busy), 8'h01);
        cyc(1);
        chk("b9_deb_abort", 8'(busy),      8'h00);
        chk("b9_col_wrap",  8'(col_drive), 8'h01);
        cyc(19);
        chk("b9_no_emit", 8'(key_valid), 8'h00);
        cyc(1);
        chk("b9_valid", 8'(key_valid), 8'h01);
        chk("b9_code",  8'(key_code),  8'h09);

        cyc(5);
        key_down = 1'b0;
        cyc(10);
        chk("ov_col_after_rel", 8'(col_drive), 8'h01);
        chk("ov_valid_pend",    8'(key_valid), 8'h01);
        press(2'd3, 2'd2);
        cyc(19);
        chk("ov_not_yet", 8'(overrun), 8'h00);
        cyc(1);
        chk("ov_set",   8'(overrun),   8'h01);
        chk("ov_code",  8'(key_code),  8'h09);
        chk("ov_valid", 8'(key_valid), 8'h01);
        key_ready = 1'b1;
        cyc(1);
        key_ready = 1'b0;
        chk("ov_ack",    8'(key_valid), 8'h00);
        chk("ov_sticky", 8'(overrun),   8'h01);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("ov_clr", 8'(overrun), 8'h00);

        key_down = 1'b0;
        cyc(10);
        chk("gh_start_col", 8'(col_drive), 8'h01);
        ghost = 1'b1;
        cyc(4);
        chk("gh_col1", 8'(col_drive), 8'h02);
        chk("gh_busy", 8'(busy),      8'h00);
        cyc(4);
        chk("gh_col2", 8'(col_drive), 8'h04);
        cyc(4);
        chk("gh_col0", 8'(col_drive), 8'h01);
        cyc(4);
        chk("gh_col1b",  8'(col_drive), 8'h02);
        chk("gh_busy2",  8'(busy),      8'h00);
        chk("gh_valid",  8'(key_valid), 8'h00);

        ghost = 1'b0;
        press(2'd0, 2'd0);
        cyc(12);
        chk("rd_busy", 8'(busy), 8'h01);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("rd_col",   8'(col_drive), 8'h01);
        chk("rd_code",  8'(key_code),  8'h00);
        chk("rd_valid", 8'(key_valid), 8'h00);
        chk("rd_busy0", 8'(busy),      8'h00);
        rst_n = 1'b1;
        cyc(12);
        chk("rh_valid", 8'(key_valid), 8'h01);
        chk("rh_code",  8'(key_code),  8'h01);
        cyc(3);
        chk("rh_busy", 8'(busy), 8'h01);
        rst_n = 1'b0;
        cyc(1);
        chk("rh_col",   8'(col_drive), 8'h01);
        chk("rh_code0", 8'(key_code),  8'h00);
        chk("rh_valid0",8'(key_valid), 8'h00);
        chk("rh_busy0", 8'(busy),      8'h00);
        rst_n = 1'b1;
        key_down = 1'b0;

`ifdef KEYPAD_REPEAT_EN
        begin
            int n_emit;
            int t_first;
            int t_last;
            int gap_ok;
            cyc(30);
            key_ready = 1'b1;
            press(2'd0, 2'd0);
            n_emit = 0; t_first = -1; t_last = -1; gap_ok = 1;
            for (int t = 0; t < 200; t++) begin
                cyc(1);
                if (key_valid === 1'b1) begin
                    if (t_first < 0) t_first = t;
                    else if (t - t_last != 64) gap_ok = 0;
                    if (t_first >= 0 && t - t_first <= 150) n_emit++;
                    t_last = t;
                end
            end
            chk("rp_count", 8'(n_emit), 8'd3);
            chk("rp_gap",   8'(gap_ok), 8'd1);
            chk("rp_code",  8'(key_code), 8'h01);
            key_ready = 1'b0;
            key_down = 1'b0;
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequential scan controller for the 4x3 matrix keypad.
- Drives one-hot column strobes, samples the row lines, and resolves exactly one pressed key per strobe.
- Debounces both press and release, encodes the key to a 4-bit code and presents it on a valid/ready handshake.
- Sits between the keypad pins and the key consumer (display or entry logic).

Parameters:
- SCAN_DIV, 4: clock cycles each column is driven before its rows are sampled; must be >= 3 to cover synchronizer latency.
- DEBOUNCE, 8: consecutive stable cycles required to confirm a press or a release; must be >= 2.
- REPEAT_PERIOD, 64: cycles between auto-repeat emissions; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- scan_en  in  1  1 = scanning enabled.
- row_in  in  4  raw row lines, active-high; bit r = row r.
- col_drive  out  3  one-hot column strobe; bit c = column c.
- key_code  out  4  encoded key.
- key_valid  out  1  a key code is pending.
- key_ready  in  1  consumer accepts key_code.
- overrun  out  1  sticky: a key was dropped.
- overrun_clr  in  1  clears overrun.
- busy  out  1  high in any state other than SCAN.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: col_drive = 001, key_code = 0, key_valid = 0, overrun = 0, busy = 0, state = SCAN, all counters = 0, synchronizer = 0. Reset asserted in any state aborts that state; outputs take reset values at that edge.
- Synchronizer: row_in passes through a 2-flop synchronizer; rs denotes its output. All decisions use rs.
- Key encoding, row r / column c:
  - rows 0-2: code = 3r + c + 1 (keys 1..9).
  - row 3, column 0: 4'hA (*).
  - row 3, column 1: 4'h0.
  - row 3, column 2: 4'hB (#).
- State SCAN:
  - col_drive = one-hot of cur_col; scan counter sc increments each cycle.
  - At sc == SCAN_DIV-1, evaluate rs:
    - Exactly one bit set: capture row and column, clear the debounce counter dc, go to DEB_PRESS. cur_col stays frozen.
    - Zero or more than one bit set (ghost reject): advance cur_col 0->1->2->0 and clear sc.
- State DEB_PRESS:
  - rs equal to the captured row: dc++.
  - When dc reaches DEBOUNCE-1: emit the key and go to HELD.
  - Any mismatch: go to SCAN with the next column and sc = 0.
- Emit (single cycle):
  - key_valid = 0: load key_code, set key_valid = 1.
  - key_valid = 1 and key_ready = 1 in the same cycle: load the new code, key_valid stays 1.
  - key_valid = 1 and key_ready = 0: set overrun = 1; key_code is unchanged.
- State HELD:
  - Release counter rc increments while rs == 0000 and clears on any nonzero rs.
  - When rc reaches DEBOUNCE-1: go to SCAN with the next column and sc = 0.
- Handshake: key_valid is cleared when key_ready = 1 and no emit occurs in that cycle. key_ready while key_valid = 0 is ignored.
- overrun:
  - Set by a dropped emit; cleared by overrun_clr.
  - A set and a clear in the same cycle: the set wins.
- scan_en = 0:
  - col_drive = 000, state forced to SCAN, cur_col = 0, all counters cleared.
  - key_valid, key_code and overrun are held; the handshake still operates.
- Latency from row stable (synchronized) in a sampled column to key_valid: DEBOUNCE + 1 cycles after the sample point.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter counts while the key stays pressed (rs == captured row). Every REPEAT_PERIOD cycles it performs an emit of the same code, with the same overrun rules. The counter clears on entry to HELD and on any rc increment.
- Not defined: exactly one emission per debounced press; the REPEAT_PERIOD logic is absent.

Test Plan:
All scenarios use SCAN_DIV = 4, DEBOUNCE = 8.
- Reset: rst_n = 0 for 3 cycles with row_in = 1111 -> col_drive = 001, key_code = 0, key_valid = 0, overrun = 0, busy = 0.
- Key 5: row_in = 0010 whenever col_drive = 010, held 40 cycles -> key_code = 5, key_valid = 1 until the key_ready pulse; col_drive stays 010 until 8 cycles after release, then goes to 100.
- Bounce: key 9 (row 2, column 2) toggling every 2 cycles for 6 cycles, then stable -> exactly one emission, key_code = 9; no emission during the toggle phase.
- Ghosting: row_in = 0011 in column 0, held -> no key_valid; col_drive keeps rotating 001 -> 010 -> 100.
- Overrun: press 9 and leave it unacknowledged; release, then press # -> overrun = 1, key_code = 9. key_ready = 1 -> key_valid = 0. overrun_clr -> overrun = 0.
- Reset mid-operation: rst_n = 0 during DEB_PRESS and again during HELD -> reset values at the next edge. Macro build: hold key 1 for 200 cycles -> 3 emissions of code 1 spaced 64 cycles apart with key_ready tied high.
